// File: rtl/ktc16_cpu.sv
// ktc16_cpu: 16-bit two-cycle (FETCH/EXECUTE) processor with eight general
// registers and one shared byte-addressed RAM port (async 32-bit read,
// synchronous 16-bit write).
module ktc16_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd,
    output logic        memwrite,
    output logic [15:0] addr,
    output logic [15:0] wd
);

    typedef enum logic {
        FETCH,
        EXECUTE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_ADDI = 4'd8,
        OP_LW   = 4'd9,
        OP_SW   = 4'd10,
        OP_BEQ  = 4'd11,
        OP_BNE  = 4'd12,
        OP_JAL  = 4'd13,
        OP_NOP0 = 4'd14,
        OP_NOP1 = 4'd15
    } op_t;

    state_t      state;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [15:0] regs [8];

    op_t         op;
    logic [2:0]  ra_idx;
    logic [2:0]  rb_idx;
    logic [2:0]  rc_idx;
    logic [15:0] imm;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] vc;
    logic [15:0] ea;
    logic [15:0] pc_plus4;
    logic [15:0] pc_next;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        is_mem;
    logic        unused_ir_bits;

    assign op             = op_t'(ir[31:28]);
    assign ra_idx         = ir[26:24];
    assign rb_idx         = ir[22:20];
    assign rc_idx         = ir[18:16];
    assign imm            = ir[15:0];
    assign unused_ir_bits = ^{ir[27], ir[23], ir[19]};

    // Register reads; r0 is hard-wired to zero regardless of storage contents.
    always_comb begin
        va = (ra_idx == 3'd0) ? '0 : regs[ra_idx];
        vb = (rb_idx == 3'd0) ? '0 : regs[rb_idx];
        vc = (rc_idx == 3'd0) ? '0 : regs[rc_idx];
    end

    // Decode/execute: result, write enable and next PC for the current IR.
    always_comb begin
        pc_plus4 = pc + 16'd4;
        ea       = vb + imm;
        pc_next  = pc_plus4;
        wr_data  = '0;
        wr_en    = 1'b0;
        is_mem   = 1'b0;
        case (op)
            OP_ADD:  begin wr_data = vb + vc; wr_en = 1'b1; end
            OP_SUB:  begin wr_data = vb - vc; wr_en = 1'b1; end
            OP_AND:  begin wr_data = vb & vc; wr_en = 1'b1; end
            OP_OR:   begin wr_data = vb | vc; wr_en = 1'b1; end
            OP_XOR:  begin wr_data = vb ^ vc; wr_en = 1'b1; end
            OP_SLT:  begin
                wr_data = ($signed(vb) < $signed(vc)) ? 16'd1 : 16'd0;
                wr_en   = 1'b1;
            end
            OP_SLL:  begin wr_data = vb << vc[3:0]; wr_en = 1'b1; end
            OP_SRL:  begin wr_data = vb >> vc[3:0]; wr_en = 1'b1; end
            OP_ADDI: begin wr_data = vb + imm; wr_en = 1'b1; end
            OP_LW:   begin wr_data = rd[15:0]; wr_en = 1'b1; is_mem = 1'b1; end
            OP_SW:   is_mem = 1'b1;
            OP_BEQ:  if (va == vb) pc_next = pc + imm;
            OP_BNE:  if (va != vb) pc_next = pc + imm;
            // Target uses the pre-write rb, so ra==rb links and jumps correctly.
            OP_JAL:  begin wr_data = pc_plus4; wr_en = 1'b1; pc_next = vb + imm; end
            default: ;
        endcase
    end

    // RAM port; reset suppresses any store in flight on the same edge.
    always_comb begin
        memwrite = !reset && (state == EXECUTE) && (op == OP_SW);
        addr     = (!reset && (state == EXECUTE) && is_mem) ? ea : pc;
        wd       = memwrite ? va : '0;
    end

    // Two-state sequencer holding PC, IR and the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= rd;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    pc    <= pc_next;
                    if (wr_en && (ra_idx != 3'd0)) begin
                        regs[ra_idx] <= wr_data;
                    end
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ktc16_cpu.sv
// tb_ktc16_cpu: runs small programs from a behavioural RAM and scores every
// store pulse against a queue of expected (address, data) pairs.
module tb_ktc16_cpu;

    logic        clk;
    logic        reset;
    logic [31:0] rd;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] wd;

    logic [7:0]  mem [65536];
    logic [31:0] sb_q [$];
    logic [31:0] sb_e;
    logic [15:0] ld_pc;
    int          checks;
    int          errors;

    ktc16_cpu #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .memwrite (memwrite),
        .addr     (addr),
        .wd       (wd)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous little-endian 32-bit read
    assign rd = {mem[addr + 16'd3], mem[addr + 16'd2], mem[addr + 16'd1], mem[addr]};

    // Synchronous 16-bit little-endian write
    always @(posedge clk) begin
        if (memwrite) begin
            mem[addr]          = wd[7:0];
            mem[addr + 16'd1]  = wd[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Score each store pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (memwrite === 1'b1) begin
            check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check("st_addr", {16'd0, addr}, {16'd0, sb_e[31:16]});
                check("st_wd", {16'd0, wd}, {16'd0, sb_e[15:0]});
            end
        end
    end

    // Encoding; the ignored bits 27/23/19 are set to show they are don't-care.
    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c,
                                        input logic [15:0] imm);
        return {op, 1'b1, a, 1'b1, b, 1'b1, c, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        ld_pc = 16'h0000;
    endtask

    task automatic emit(input logic [31:0] w);
        mem[ld_pc]          = w[7:0];
        mem[ld_pc + 16'd1]  = w[15:8];
        mem[ld_pc + 16'd2]  = w[23:16];
        mem[ld_pc + 16'd3]  = w[31:24];
        ld_pc = ld_pc + 16'd4;
    endtask

    task automatic expect_st(input logic [15:0] a, input logic [15:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memwrite", {31'd0, memwrite}, 32'd0);
        check("rst_addr", {16'd0, addr}, 32'd0);
        check("rst_wd", {16'd0, wd}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (12) @(posedge clk);
        #1;
        check("drain", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    localparam logic [31:0] HALT = 32'hB888_0000;

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;

        // Fibonacci: loop until r2==144, then a single store to 80
        clear_mem();
        emit(enc(8, 1, 0, 0, 16'd1));
        emit(enc(8, 2, 0, 0, 16'd1));
        emit(enc(8, 4, 0, 0, 16'd144));
        emit(enc(0, 3, 1, 2, 16'd0));
        emit(enc(0, 1, 2, 0, 16'd0));
        emit(enc(0, 2, 3, 0, 16'd0));
        emit(enc(12, 2, 4, 0, -16'd12));
        emit(enc(10, 2, 0, 0, 16'd80));
        emit(HALT);
        expect_st(16'd80, 16'd144);
        do_reset();
        drain(2000);

        // ALU, r0 immutability, load/store
        clear_mem();
        emit(enc(8, 1, 0, 0, 16'h7FFF));
        emit(enc(8, 2, 0, 0, 16'h0001));
        emit(enc(0, 3, 1, 2, 16'd0));
        emit(enc(1, 4, 0, 2, 16'd0));
        emit(enc(5, 5, 4, 2, 16'd0));
        emit(enc(7, 6, 4, 2, 16'd0));
        emit(enc(10, 3, 0, 0, 16'h0200)); expect_st(16'h0200, 16'h8000);
        emit(enc(10, 4, 0, 0, 16'h0202)); expect_st(16'h0202, 16'hFFFF);
        emit(enc(10, 5, 0, 0, 16'h0204)); expect_st(16'h0204, 16'h0001);
        emit(enc(10, 6, 0, 0, 16'h0206)); expect_st(16'h0206, 16'h7FFF);
        emit(enc(6, 7, 4, 2, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h0208)); expect_st(16'h0208, 16'hFFFE);
        emit(enc(4, 7, 3, 4, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h020A)); expect_st(16'h020A, 16'h7FFF);
        emit(enc(2, 7, 3, 4, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h020C)); expect_st(16'h020C, 16'h8000);
        emit(enc(3, 7, 1, 3, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h020E)); expect_st(16'h020E, 16'hFFFF);
        emit(enc(5, 7, 2, 4, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h0210)); expect_st(16'h0210, 16'h0000);
        emit(enc(8, 0, 0, 0, 16'd5));
        emit(enc(10, 0, 0, 0, 16'h0212)); expect_st(16'h0212, 16'h0000);
        emit(enc(10, 3, 0, 0, 16'h0100)); expect_st(16'h0100, 16'h8000);
        emit(enc(9, 7, 0, 0, 16'h0100));
        emit(enc(10, 7, 0, 0, 16'h0214)); expect_st(16'h0214, 16'h8000);
        emit(enc(8, 6, 0, 0, 16'h0011));
        emit(enc(7, 7, 1, 6, 16'd0));
        emit(enc(10, 7, 0, 0, 16'h0216)); expect_st(16'h0216, 16'h3FFF);
        emit(HALT);
        do_reset();
        drain(2000);

        // Control flow: BEQ back by 4, BNE fall-through, JAL (incl. ra==rb)
        clear_mem();
        emit(enc(8, 3, 0, 0, 16'd1));
        emit(enc(8, 4, 0, 0, 16'd2));
        emit(enc(8, 1, 1, 0, 16'd1));
        emit(enc(11, 1, 3, 0, -16'd4));
        emit(enc(10, 1, 0, 0, 16'h0300)); expect_st(16'h0300, 16'd2);
        emit(enc(12, 1, 4, 0, 16'd8));
        emit(enc(8, 5, 0, 0, 16'h0055));
        emit(enc(10, 5, 0, 0, 16'h0302)); expect_st(16'h0302, 16'h0055);
        emit(enc(13, 7, 3, 0, 16'h003F));
        emit(enc(8, 5, 0, 0, 16'h0BAD));
        ld_pc = 16'd64;
        emit(enc(10, 7, 0, 0, 16'h0304)); expect_st(16'h0304, 16'd36);
        emit(enc(10, 5, 0, 0, 16'h0306)); expect_st(16'h0306, 16'h0055);
        emit(enc(13, 6, 6, 0, 16'h0050));
        emit(enc(8, 5, 0, 0, 16'h0001));
        emit(enc(10, 6, 0, 0, 16'h0308)); expect_st(16'h0308, 16'd76);
        emit(enc(10, 5, 0, 0, 16'h030A)); expect_st(16'h030A, 16'h0055);
        emit(HALT);
        do_reset();
        drain(2000);

        // Reset landing on the EXECUTE cycle of a store
        clear_mem();
        emit(enc(8, 1, 0, 0, 16'h1234));
        emit(enc(10, 1, 0, 0, 16'h0400));
        emit(HALT);
        do_reset();
        n = 0;
        while (memwrite !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sw_reached", {31'd0, memwrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_memwrite", {31'd0, memwrite}, 32'd0);
        check("mid_rst_wd", {16'd0, wd}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_addr", {16'd0, addr}, 32'd0);
        check("mid_rst_ram", {16'd0, mem[16'h0401], mem[16'h0400]}, 32'd0);
        // Replace the r1 setup with a NOP so the rerun exposes r1's reset value
        ld_pc = 16'h0000;
        emit(enc(14, 1, 0, 0, 16'h1234));
        expect_st(16'h0400, 16'h0000);
        reset = 1'b0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
